// File: rtl/qsn_shift_seq_len15_pkg.sv
// Shared constants, FSM encodings and the merge-mask helper for the QSN shift sequencer.
package qsn_pkg;

  localparam int PC        = 15;
  localparam int SEL_W     = 4;
  localparam int MAX_LAYER = 4;
  localparam int MAX_COL   = 8;
  localparam int QSN_LAT   = 2;

  localparam int TBL_DEPTH = MAX_LAYER * MAX_COL;
  localparam int ADDR_W    = $clog2(TBL_DEPTH);
  localparam int LAYER_W   = $clog2(MAX_LAYER);
  localparam int COL_W     = $clog2(MAX_COL);
  localparam int CNUM_W    = COL_W + 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Lane k of the merge network takes the left path when k < n.
  function automatic logic [PC-2:0] merge_mask(input logic [SEL_W-1:0] n);
    logic [PC-2:0] m;
    m = '0;
    for (int k = 0; k < PC - 1; k++) begin
      m[k] = (k < int'(n));
    end
    return m;
  endfunction

endpackage

// File: rtl/qsn_shift_seq_len15_if.sv
// Table-write, sweep-command and shifter-select bundle of the QSN shift sequencer.
interface qsn_shift_seq_len15_if;
  import qsn_pkg::*;

  logic                tbl_we;
  logic [ADDR_W-1:0]   tbl_waddr;
  logic [SEL_W-1:0]    tbl_wdata;
  logic                start;
  logic [LAYER_W-1:0]  layer_id;
  logic [CNUM_W-1:0]   col_num;
  logic [SEL_W-1:0]    z_size;
  logic                busy;
  logic [SEL_W-1:0]    left_sel;
  logic [SEL_W-1:0]    right_sel;
  logic [PC-2:0]       merge_sel;
  logic                sel_valid;
  logic                out_valid;
  logic [COL_W-1:0]    out_col_idx;
  logic                done;
  logic                err_cfg;

  modport master (
    output tbl_we, tbl_waddr, tbl_wdata, start, layer_id, col_num, z_size,
    input  busy, left_sel, right_sel, merge_sel, sel_valid, out_valid,
           out_col_idx, done, err_cfg
  );

  modport slave (
    input  tbl_we, tbl_waddr, tbl_wdata, start, layer_id, col_num, z_size,
    output busy, left_sel, right_sel, merge_sel, sel_valid, out_valid,
           out_col_idx, done, err_cfg
  );

endinterface

// File: rtl/qsn_shift_seq_len15_tbl.sv
// Register-file shift table: one synchronous write port, one combinational read port.
module qsn_shift_tbl
  import qsn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [SEL_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [SEL_W-1:0]  rdata
);

  logic [SEL_W-1:0] mem_q [TBL_DEPTH];
  logic [SEL_W-1:0] mem_d [TBL_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/qsn_shift_seq_len15.sv
// Per-layer shift-control sequencer feeding the 15-lane QSN barrel shifter.
module qsn_shift_seq_len15
  import qsn_pkg::*;
(
  input logic                  sys_clk,
  input logic                  rst,
  qsn_shift_seq_len15_if.slave bus
);

  localparam int DRAIN_W = $clog2(QSN_LAT + 1);

  state_t               state_q, state_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;
  logic [CNUM_W-1:0]    cnum_q, cnum_d;
  logic [SEL_W-1:0]     z_q, z_d;
  logic [COL_W-1:0]     c_q, c_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 err_q, err_d;
  logic [SEL_W-1:0]     left_q, left_d;
  logic [SEL_W-1:0]     right_q, right_d;
  logic [PC-2:0]        merge_q, merge_d;
  logic                 sel_valid_q, sel_valid_d;
  logic [COL_W-1:0]     sel_col_q, sel_col_d;
  logic [QSN_LAT-1:0]   vpipe_q, vpipe_d;
  logic [COL_W-1:0]     cpipe_q [QSN_LAT];
  logic [COL_W-1:0]     cpipe_d [QSN_LAT];
  logic                 done_q, done_d;

  logic                 idle;
  logic                 cfg_bad;
  logic                 issue;
  logic [LAYER_W-1:0]   rd_layer;
  logic [COL_W-1:0]     rd_col;
  logic [SEL_W-1:0]     rd_z;
  logic [SEL_W-1:0]     s;
  logic [SEL_W-1:0]     diff;
  logic [ADDR_W-1:0]    raddr;

  qsn_shift_tbl u_tbl (
    .clk   (sys_clk),
    .rst   (rst),
    .we    (bus.tbl_we),
    .waddr (bus.tbl_waddr),
    .wdata (bus.tbl_wdata),
    .raddr (raddr),
    .rdata (s)
  );

  // Column 0 is issued on the accepting edge, so IDLE reads with the live command inputs.
  assign idle     = (state_q == ST_IDLE);
  assign rd_layer = idle ? bus.layer_id : layer_q;
  assign rd_col   = idle ? '0 : c_q;
  assign rd_z     = idle ? bus.z_size : z_q;
  assign raddr    = {rd_layer, rd_col};
  assign diff     = rd_z - s;
  assign cfg_bad  = (bus.z_size == '0) || (int'(bus.z_size) > PC) ||
                    (bus.col_num == '0) || (int'(bus.col_num) > MAX_COL);

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    cnum_d      = cnum_q;
    z_d         = z_q;
    c_d         = c_q;
    drain_d     = drain_q;
    err_d       = err_q;
    left_d      = left_q;
    right_d     = right_q;
    merge_d     = merge_q;
    sel_valid_d = 1'b0;
    sel_col_d   = sel_col_q;
    done_d      = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            layer_d = bus.layer_id;
            cnum_d  = bus.col_num;
            z_d     = bus.z_size;
            c_d     = COL_W'(1);
            drain_d = '0;
            issue   = 1'b1;
            state_d = (bus.col_num == CNUM_W'(1)) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        c_d   = c_q + COL_W'(1);
        if ({1'b0, c_q} == cnum_q - CNUM_W'(1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(QSN_LAT)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An out-of-range shift still occupies its slot, issued as a pass-through on the right path.
    if (issue) begin
      sel_valid_d = 1'b1;
      sel_col_d   = rd_col;
      if (s >= rd_z) begin
        err_d   = 1'b1;
        left_d  = '0;
        right_d = rd_z;
        merge_d = '0;
      end else begin
        left_d  = s;
        right_d = diff;
        merge_d = merge_mask(diff);
      end
    end

    vpipe_d[0] = sel_valid_q;
    cpipe_d[0] = sel_col_q;
    for (int i = 1; i < QSN_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      cpipe_d[i] = cpipe_q[i-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      cnum_q      <= '0;
      z_q         <= '0;
      c_q         <= '0;
      drain_q     <= '0;
      err_q       <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      merge_q     <= '0;
      sel_valid_q <= 1'b0;
      sel_col_q   <= '0;
      vpipe_q     <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < QSN_LAT; i++) begin
        cpipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      cnum_q      <= cnum_d;
      z_q         <= z_d;
      c_q         <= c_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
      left_q      <= left_d;
      right_q     <= right_d;
      merge_q     <= merge_d;
      sel_valid_q <= sel_valid_d;
      sel_col_q   <= sel_col_d;
      vpipe_q     <= vpipe_d;
      done_q      <= done_d;
      cpipe_q     <= cpipe_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.left_sel    = left_q;
  assign bus.right_sel   = right_q;
  assign bus.merge_sel   = merge_q;
  assign bus.sel_valid   = sel_valid_q;
  assign bus.out_valid   = vpipe_q[QSN_LAT-1];
  assign bus.out_col_idx = cpipe_q[QSN_LAT-1];
  assign bus.done        = done_q;
  assign bus.err_cfg     = err_q;

endmodule

// File: doc/qsn_shift_seq_len15.md
Name: qsn_shift_seq_len15

Overview:
- Per-layer shift-control sequencer directly upstream of the 15-lane, 4-bit QSN barrel shifter.
- Stores the cyclic-shift factor of every (layer, column) circulant in a small register table.
- On start, walks the columns of one layer and drives one left_sel/right_sel/merge_sel triple per cycle.
- Tracks QSN latency so out_valid/out_col_idx are aligned with the shifter's registered outputs; flags illegal configurations.

Parameters:
- PC, 15, lane count of the shifter (merge_sel width = PC-1)
- SEL_W, 4, width of shift factors and left/right selects
- MAX_LAYER, 4, number of layers held in the shift table
- MAX_COL, 8, max circulant columns per layer
- QSN_LAT, 2, cycles from sel presentation to valid shifter output

Ports:
- sys_clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- tbl_we  in  1  shift-table write strobe
- tbl_waddr  in  $clog2(MAX_LAYER*MAX_COL)  table index = layer*MAX_COL+col
- tbl_wdata  in  SEL_W  shift factor s
- start  in  1  launch one layer sweep (accepted only when !busy)
- layer_id  in  $clog2(MAX_LAYER)  layer to sweep, sampled with start
- col_num  in  $clog2(MAX_COL)+1  columns in layer, 1..MAX_COL, sampled with start
- z_size  in  SEL_W  circulant size Z, 1..PC, sampled with start
- busy  out  1  sweep in progress (RUN or DRAIN)
- left_sel  out  SEL_W  to shifter left network
- right_sel  out  SEL_W  to shifter right network
- merge_sel  out  PC-1  to shifter merge network
- sel_valid  out  1  current sel triple is meaningful
- out_valid  out  1  shifter output of column out_col_idx is valid this cycle
- out_col_idx  out  $clog2(MAX_COL)  column tag aligned with out_valid
- done  out  1  one-cycle pulse after last out_valid
- err_cfg  out  1  sticky configuration error

Behaviour:
- Reset: all table entries 0; state IDLE; every output 0; err_cfg cleared only by rst.
- Table write: tbl_we writes tbl_wdata at tbl_waddr next edge; writes are legal in any state; a write to the entry being read in the same cycle returns the old value (read-before-write).
- FSM IDLE -> RUN on start && !busy: latch layer_id, col_num, z_size; col counter c=0.
- start while busy: ignored, no effect.
- RUN, each cycle: read s = tbl[layer*MAX_COL+c]; register outputs next edge:
  - left_sel = s; right_sel = Z - s (SEL_W-bit, s=0 gives Z)
  - merge_sel[k] = 1 (select left) iff k < Z-s, else 0, for k = 0..PC-2
  - sel_valid = 1
- RUN: c increments each cycle; after c = col_num-1 is issued -> DRAIN.
- DRAIN: sel_valid=0; selects hold their last value; after QSN_LAT cycles -> IDLE with done=1 for one cycle (in the same cycle as the last out_valid + 1).
- Alignment: out_valid/out_col_idx are sel_valid/c delayed by exactly QSN_LAT cycles through a shift register; first out_valid appears QSN_LAT cycles after first sel_valid.
- Throughput: one column per cycle; total sweep col_num + QSN_LAT + 1 cycles from start to done.
- Config checks at start:
  - z_size = 0, z_size > PC, col_num = 0, or col_num > MAX_COL -> err_cfg=1, start rejected, stay IDLE, no done.
- Per-column check: s >= Z -> err_cfg=1; sweep continues; that column is issued with left_sel=0, right_sel=Z, merge_sel all 0.
- rst mid-sweep: pipeline flushed; no out_valid or done issued afterwards.

Decomposition:
- Shared package qsn_pkg: PC, SEL_W, MAX_LAYER, MAX_COL, QSN_LAT, FSM state enum {IDLE, RUN, DRAIN}, merge-mask function.
- One sub-module qsn_shift_tbl: register-file shift table, one synchronous write port, one combinational read port.

Test Plan:
- Load layer 0 cols 0..2 with s = 0, 3, 14; start with Z=15, col_num=3 -> sel_valid cycles 1..3 with:
  - (left,right) = (0,15), (3,12), (14,1)
  - merge_sel = 0x3FFF, 0x0FFF, 0x0001
  - out_valid cycles 3..5 with idx 0,1,2; done at cycle 6.
- Z=7, s=2 -> right_sel=5, merge_sel=0x001F; err_cfg stays 0.
- Layer 1 col 0 s=9 with Z=7 -> err_cfg=1, column issued with left=0, right=7, merge 0; remaining columns normal; done still pulses.
- Start with z_size=0, then col_num=9 -> err_cfg=1, busy never asserts, no done.
- start asserted during RUN with a different layer_id -> ignored; sweep outputs unchanged.
- rst pulse two cycles into a 5-column sweep -> all outputs 0 next cycle; no further out_valid or done.
